// File: rtl/accu_core.sv
// accu_core: parametrised accumulator core with register file, jumps, HALT and a
// stalling req/ack data-memory port. Define ACCU_CORE_CALL_EN to add CALL/RET with a return stack.
module accu_core #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 6,
    parameter int REG_N   = 16,
    parameter int STACK_D = 4
) (
    input  logic              clk,
    input  logic              nReset,
    output logic [PC_W-1:0]   pm_addr,
    input  logic [DATA_W+4:0] pm_ins,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic [DATA_W-1:0] accu,
    output logic              carry,
    output logic              zero,
    output logic              halted
);

    localparam int INS_W  = DATA_W + 5;
    localparam int RIDX_W = $clog2(REG_N);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_LDR  = 5'b00010;
    localparam logic [4:0] OP_STR  = 5'b00011;
    localparam logic [4:0] OP_LDM  = 5'b00100;
    localparam logic [4:0] OP_STM  = 5'b00101;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_JZ   = 5'b01001;
    localparam logic [4:0] OP_JNZ  = 5'b01010;
    localparam logic [4:0] OP_JC   = 5'b01011;
    localparam logic [4:0] OP_JNC  = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b01111;

    if (PC_W > DATA_W || REG_N < 2 || STACK_D < 1) begin : g_paramCheck
        $error("accu_core: unsupported parameter combination");
    end

    logic [PC_W-1:0]   r_pc;
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_accu;
    logic              r_carry;
    logic              r_zero;
    logic [DATA_W-1:0] r_regs [REG_N];
    logic              r_dmReq;
    logic              r_dmWe;
    logic [DATA_W-1:0] r_dmAddr;
    logic [DATA_W-1:0] r_dmWdata;

    logic [4:0]        w_op;
    logic [DATA_W-1:0] w_k;
    logic [RIDX_W-1:0] w_ridx;
    logic [DATA_W-1:0] w_srcB;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_aluRes;
    logic              w_aluCarry;
    logic [PC_W-1:0]   w_pcInc;
    logic [PC_W-1:0]   w_jmpTarget;
    logic              w_jmpTaken;

    assign w_op        = pm_ins[INS_W-1:DATA_W];
    assign w_k         = pm_ins[DATA_W-1:0];
    assign w_ridx      = w_k[RIDX_W-1:0];
    assign w_srcB      = w_op[3] ? r_regs[w_ridx] : w_k;
    assign w_pcInc     = r_pc + PC_W'(1);
    assign w_jmpTarget = w_k[PC_W-1:0];

`ifdef ACCU_CORE_CALL_EN
    localparam logic [4:0] OP_CALL = 5'b01101;
    localparam logic [4:0] OP_RET  = 5'b01110;
    localparam int SP_W   = $clog2(STACK_D + 1);
    localparam int STK_IW = (STACK_D > 1) ? $clog2(STACK_D) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);

    logic [PC_W-1:0]   r_stack [STACK_D];
    logic [SP_W-1:0]   r_sp;
    logic [STK_IW-1:0] w_pushIdx;
    logic [STK_IW-1:0] w_popIdx;

    assign w_pushIdx = STK_IW'(r_sp);
    assign w_popIdx  = STK_IW'(r_sp - SP_W'(1));
`endif

    // Carry out of the widened sum serves ADD/ADC/SUB; SUB's carry means "no borrow".
    always_comb begin
        w_sum      = '0;
        w_aluRes   = '0;
        w_aluCarry = r_carry;
        case (w_op[2:0])
            3'd0: begin
                w_sum      = {1'b0, r_accu} + {1'b0, w_srcB};
                w_aluRes   = w_sum[DATA_W-1:0];
                w_aluCarry = w_sum[DATA_W];
            end
            3'd1: begin
                w_sum      = {1'b0, r_accu} + {1'b0, w_srcB} + {{DATA_W{1'b0}}, r_carry};
                w_aluRes   = w_sum[DATA_W-1:0];
                w_aluCarry = w_sum[DATA_W];
            end
            3'd2: begin
                w_sum      = {1'b0, r_accu} + {1'b0, ~w_srcB} + (DATA_W+1)'(1);
                w_aluRes   = w_sum[DATA_W-1:0];
                w_aluCarry = w_sum[DATA_W];
            end
            3'd3: w_aluRes = r_accu & w_srcB;
            3'd4: w_aluRes = r_accu | w_srcB;
            3'd5: w_aluRes = r_accu ^ w_srcB;
            3'd6: begin
                w_aluRes   = {r_accu[DATA_W-2:0], 1'b0};
                w_aluCarry = r_accu[DATA_W-1];
            end
            default: begin
                w_aluRes   = {1'b0, r_accu[DATA_W-1:1]};
                w_aluCarry = r_accu[0];
            end
        endcase
    end

    always_comb begin
        w_jmpTaken = 1'b0;
        case (w_op)
            OP_JMP:  w_jmpTaken = 1'b1;
            OP_JZ:   w_jmpTaken = r_zero;
            OP_JNZ:  w_jmpTaken = ~r_zero;
            OP_JC:   w_jmpTaken = r_carry;
            OP_JNC:  w_jmpTaken = ~r_carry;
            default: w_jmpTaken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_pc      <= '0;
            r_state   <= ST_RUN;
            r_accu    <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_dmReq   <= 1'b0;
            r_dmWe    <= 1'b0;
            r_dmAddr  <= '0;
            r_dmWdata <= '0;
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
`ifdef ACCU_CORE_CALL_EN
            r_sp <= '0;
            for (int i = 0; i < STACK_D; i++) begin
                r_stack[i] <= '0;
            end
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_pc <= w_jmpTaken ? w_jmpTarget : w_pcInc;
                    if (w_op[4]) begin
                        r_accu  <= w_aluRes;
                        r_carry <= w_aluCarry;
                        r_zero  <= (w_aluRes == '0);
                    end else begin
                        case (w_op)
                            OP_LDI: begin
                                r_accu <= w_k;
                                r_zero <= (w_k == '0);
                            end
                            OP_LDR: begin
                                r_accu <= r_regs[w_ridx];
                                r_zero <= (r_regs[w_ridx] == '0);
                            end
                            OP_STR: r_regs[w_ridx] <= r_accu;
                            // PC holds until the transfer is acknowledged.
                            OP_LDM, OP_STM: begin
                                r_pc      <= r_pc;
                                r_dmReq   <= 1'b1;
                                r_dmWe    <= w_op[0];
                                r_dmAddr  <= w_k;
                                r_dmWdata <= r_accu;
                                r_state   <= ST_WAIT;
                            end
                            OP_HALT: begin
                                r_pc    <= r_pc;
                                r_state <= ST_HALT;
                            end
`ifdef ACCU_CORE_CALL_EN
                            // A full stack still jumps; the return address is simply lost.
                            OP_CALL: begin
                                r_pc <= w_jmpTarget;
                                if (r_sp != SP_FULL) begin
                                    r_stack[w_pushIdx] <= w_pcInc;
                                    r_sp               <= r_sp + SP_W'(1);
                                end
                            end
                            OP_RET: begin
                                if (r_sp != '0) begin
                                    r_pc <= r_stack[w_popIdx];
                                    r_sp <= r_sp - SP_W'(1);
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (dm_ack) begin
                        r_dmReq <= 1'b0;
                        r_pc    <= w_pcInc;
                        r_state <= ST_RUN;
                        if (!r_dmWe) begin
                            r_accu <= dm_rdata;
                            r_zero <= (dm_rdata == '0);
                        end
                    end
                end
                ST_HALT: ;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign pm_addr  = r_pc;
    assign dm_req   = r_dmReq;
    assign dm_we    = r_dmWe;
    assign dm_addr  = r_dmAddr;
    assign dm_wdata = r_dmWdata;
    assign accu     = r_accu;
    assign carry    = r_carry;
    assign zero     = r_zero;
    assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_accu_core.sv
// tb_accu_core: directed programs for accu_core checked against an instruction-level
// model every cycle, plus literal expectations; CALL/RET program runs under ACCU_CORE_CALL_EN.
module tb_accu_core;

    logic        clk;
    logic        nReset;
    logic [5:0]  pm_addr;
    logic [12:0] pm_ins;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic [7:0]  dm_rdata;
    logic        dm_ack;
    logic [7:0]  accu;
    logic        carry;
    logic        zero;
    logic        halted;

    logic [12:0] progMem [64];
    logic [7:0]  dataMem [256];
    int          ackDelay;
    int          reqCnt;
    logic        forceAck;
    logic        checkEn;
    int          checks;
    int          errors;

    // Instruction-level model state
    int mPC, mA, mC, mZ, mReq, mWe, mAddr, mWdata, mHalt, mWait;
    int mR [16];
    int mStack [$];

    accu_core #(.DATA_W(8), .PC_W(6), .REG_N(16), .STACK_D(4)) dut (
        .clk(clk), .nReset(nReset), .pm_addr(pm_addr), .pm_ins(pm_ins),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .accu(accu), .carry(carry),
        .zero(zero), .halted(halted)
    );

    assign pm_ins = progMem[pm_addr];

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic [4:0] op, input logic [7:0] k);
        return {op, k};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 64; i++) progMem[i] = 13'h0;
    endtask

    // Data-memory responder: acks after ackDelay cycles of dm_req, or on demand.
    always @(negedge clk) begin
        dm_ack   = 1'b0;
        dm_rdata = 8'hEE;
        if (forceAck) begin
            dm_ack   = 1'b1;
            dm_rdata = 8'h77;
        end else if (nReset && dm_req) begin
            reqCnt++;
            if (reqCnt >= ackDelay) begin
                dm_ack   = 1'b1;
                dm_rdata = dataMem[dm_addr];
                reqCnt   = 0;
            end
        end else begin
            reqCnt = 0;
        end
    end

    // Architectural model: one instruction (or one wait step) per rising edge.
    always @(posedge clk) begin
        logic [12:0] ins;
        int op, k, b, t, nextPC;
        if (!nReset) begin
            mPC = 0; mA = 0; mC = 0; mZ = 0; mReq = 0; mWe = 0;
            mAddr = 0; mWdata = 0; mHalt = 0; mWait = 0;
            for (int i = 0; i < 16; i++) mR[i] = 0;
            mStack.delete();
        end else if (mHalt != 0) begin
        end else if (mWait != 0) begin
            if (dm_ack === 1'b1) begin
                mReq = 0;
                mWait = 0;
                if (mWe == 0) begin
                    mA = int'(dm_rdata);
                    mZ = (mA == 0) ? 1 : 0;
                end
                mPC = (mPC + 1) % 64;
            end
        end else begin
            ins = progMem[mPC];
            op = int'(ins[12:8]);
            k = int'(ins[7:0]);
            nextPC = (mPC + 1) % 64;
            if (op >= 16) begin
                b = (op >= 24) ? mR[k % 16] : k;
                case (op % 8)
                    0: begin t = mA + b; mA = t % 256; mC = (t > 255) ? 1 : 0; end
                    1: begin t = mA + b + mC; mA = t % 256; mC = (t > 255) ? 1 : 0; end
                    2: begin mC = (mA >= b) ? 1 : 0; mA = (mA - b + 256) % 256; end
                    3: mA = mA & b;
                    4: mA = mA | b;
                    5: mA = mA ^ b;
                    6: begin mC = (mA >= 128) ? 1 : 0; mA = (mA * 2) % 256; end
                    default: begin mC = mA % 2; mA = mA / 2; end
                endcase
                mZ = (mA == 0) ? 1 : 0;
            end else begin
                case (op)
                    1: begin mA = k; mZ = (mA == 0) ? 1 : 0; end
                    2: begin mA = mR[k % 16]; mZ = (mA == 0) ? 1 : 0; end
                    3: mR[k % 16] = mA;
                    4, 5: begin
                        mReq = 1; mWe = (op == 5) ? 1 : 0; mAddr = k; mWdata = mA;
                        mWait = 1; nextPC = mPC;
                    end
                    8: nextPC = k % 64;
                    9: if (mZ == 1) nextPC = k % 64;
                    10: if (mZ == 0) nextPC = k % 64;
                    11: if (mC == 1) nextPC = k % 64;
                    12: if (mC == 0) nextPC = k % 64;
`ifdef ACCU_CORE_CALL_EN
                    13: begin
                        if (mStack.size() < 4) mStack.push_back(nextPC);
                        nextPC = k % 64;
                    end
                    14: if (mStack.size() > 0) nextPC = mStack.pop_back();
`endif
                    15: begin mHalt = 1; nextPC = mPC; end
                    default: ;
                endcase
            end
            mPC = nextPC;
        end
    end

    // Compare DUT against the model shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("pm_addr", 32'(pm_addr), 32'(mPC));
            checkOutput("accu", 32'(accu), 32'(mA));
            checkOutput("carry", 32'(carry), 32'(mC));
            checkOutput("zero", 32'(zero), 32'(mZ));
            checkOutput("halted", 32'(halted), 32'(mHalt));
            checkOutput("dm_req", 32'(dm_req), 32'(mReq));
            if (mReq != 0) begin
                checkOutput("dm_we", 32'(dm_we), 32'(mWe));
                checkOutput("dm_addr", 32'(dm_addr), 32'(mAddr));
                checkOutput("dm_wdata", 32'(dm_wdata), 32'(mWdata));
            end
        end
    end

    initial begin
        clk = 1'b0; nReset = 1'b0; forceAck = 1'b0; checkEn = 1'b0;
        ackDelay = 1; reqCnt = 0; checks = 0; errors = 0;
        dm_ack = 1'b0; dm_rdata = 8'h00;
        for (int i = 0; i < 256; i++) dataMem[i] = 8'h00;
        dataMem[8'h40] = 8'hA5;

        // Reset held two cycles with LDI 0x55 at address 0
        clearProgram();
        progMem[0] = mk(5'b00001, 8'h55);
        applyStimulus(1);
        checkEn = 1'b1;
        applyStimulus(1);
        checkOutput("rst_accu", 32'(accu), 32'h0);
        checkOutput("rst_pc", 32'(pm_addr), 32'h0);
        checkOutput("rst_req", 32'(dm_req), 32'h0);
        nReset = 1'b1;
        applyStimulus(1);
        checkOutput("ldi_accu", 32'(accu), 32'h55);
        checkOutput("ldi_pc", 32'(pm_addr), 32'h1);

        // ALU program
        nReset = 1'b0;
        clearProgram();
        progMem[0]  = mk(5'b00001, 8'hF0);
        progMem[1]  = mk(5'b10000, 8'h20);
        progMem[2]  = mk(5'b10001, 8'h00);
        progMem[3]  = mk(5'b10010, 8'h12);
        progMem[4]  = mk(5'b00011, 8'h03);
        progMem[5]  = mk(5'b00001, 8'h0F);
        progMem[6]  = mk(5'b11000, 8'h03);
        progMem[7]  = mk(5'b10101, 8'h0E);
        progMem[8]  = mk(5'b00001, 8'h81);
        progMem[9]  = mk(5'b10110, 8'h00);
        progMem[10] = mk(5'b10111, 8'h00);
        progMem[11] = mk(5'b10111, 8'h00);
        progMem[12] = mk(5'b10100, 8'h3C);
        progMem[13] = mk(5'b10011, 8'h0F);
        progMem[14] = mk(5'b00010, 8'h03);
        progMem[15] = mk(5'b11010, 8'h03);
        applyStimulus(2);
        nReset = 1'b1;
        applyStimulus(1);
        checkOutput("alu_ldi", 32'(accu), 32'hF0);
        applyStimulus(1);
        checkOutput("alu_add", 32'(accu), 32'h10);
        checkOutput("alu_add_c", 32'(carry), 32'h1);
        applyStimulus(1);
        checkOutput("alu_adc", 32'(accu), 32'h11);
        checkOutput("alu_adc_c", 32'(carry), 32'h0);
        checkOutput("alu_adc_z", 32'(zero), 32'h0);
        applyStimulus(5);
        checkOutput("alu_xor", 32'(accu), 32'h00);
        checkOutput("alu_xor_z", 32'(zero), 32'h1);
        checkOutput("alu_xor_c", 32'(carry), 32'h1);
        applyStimulus(8);
        checkOutput("alu_subr", 32'(accu), 32'h00);
        checkOutput("alu_subr_c", 32'(carry), 32'h1);

        // Memory transfers with a stalled ack
        nReset = 1'b0;
        clearProgram();
        progMem[0] = mk(5'b00001, 8'h03);
        progMem[1] = mk(5'b00101, 8'h40);
        progMem[2] = mk(5'b00100, 8'h40);
        ackDelay = 3;
        applyStimulus(2);
        nReset = 1'b1;
        applyStimulus(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("stm_req", 32'(dm_req), 32'h1);
            checkOutput("stm_we", 32'(dm_we), 32'h1);
            checkOutput("stm_addr", 32'(dm_addr), 32'h40);
            checkOutput("stm_wdata", 32'(dm_wdata), 32'h03);
            checkOutput("stm_pc_hold", 32'(pm_addr), 32'h1);
        end
        applyStimulus(1);
        checkOutput("stm_done_req", 32'(dm_req), 32'h0);
        checkOutput("stm_done_pc", 32'(pm_addr), 32'h2);
        ackDelay = 1;
        applyStimulus(1);
        checkOutput("ldm_we", 32'(dm_we), 32'h0);
        applyStimulus(1);
        checkOutput("ldm_accu", 32'(accu), 32'hA5);
        checkOutput("ldm_pc", 32'(pm_addr), 32'h3);

        // Conditional jumps and PC wrap
        nReset = 1'b0;
        clearProgram();
        progMem[0]  = mk(5'b00001, 8'h00);
        progMem[1]  = mk(5'b01001, 8'h3F);
        progMem[63] = mk(5'b01010, 8'h20);
        applyStimulus(2);
        nReset = 1'b1;
        applyStimulus(1);
        checkOutput("jz_pc1", 32'(pm_addr), 32'h01);
        applyStimulus(1);
        checkOutput("jz_taken", 32'(pm_addr), 32'h3F);
        applyStimulus(1);
        checkOutput("jnz_wrap", 32'(pm_addr), 32'h00);

        // JC/JNC/JMP then HALT
        nReset = 1'b0;
        clearProgram();
        progMem[0]  = mk(5'b00001, 8'hFF);
        progMem[1]  = mk(5'b10000, 8'h01);
        progMem[2]  = mk(5'b01100, 8'h10);
        progMem[3]  = mk(5'b01011, 8'h08);
        progMem[8]  = mk(5'b01000, 8'h0C);
        progMem[12] = mk(5'b00001, 8'h05);
        progMem[13] = mk(5'b01001, 8'h00);
        progMem[14] = mk(5'b01111, 8'h00);
        applyStimulus(2);
        nReset = 1'b1;
        applyStimulus(4);
        checkOutput("jc_taken", 32'(pm_addr), 32'h08);
        applyStimulus(4);
        checkOutput("halt_flag", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("halt_pc", 32'(pm_addr), 32'h0E);
        end

        // Reset while waiting on a transfer, then a stray ack
        nReset = 1'b0;
        clearProgram();
        progMem[0] = mk(5'b00001, 8'h11);
        progMem[1] = mk(5'b00100, 8'h40);
        ackDelay = 100;
        applyStimulus(2);
        nReset = 1'b1;
        applyStimulus(2);
        checkOutput("wait_req", 32'(dm_req), 32'h1);
        applyStimulus(1);
        nReset = 1'b0;
        clearProgram();
        applyStimulus(1);
        checkOutput("abort_req", 32'(dm_req), 32'h0);
        checkOutput("abort_accu", 32'(accu), 32'h00);
        nReset = 1'b1;
        forceAck = 1'b1;
        applyStimulus(1);
        forceAck = 1'b0;
        checkOutput("late_ack_accu", 32'(accu), 32'h00);
        checkOutput("late_ack_pc", 32'(pm_addr), 32'h01);
        ackDelay = 1;

`ifdef ACCU_CORE_CALL_EN
        begin
            int expPc [11];
            expPc = '{8'h10, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h31, 8'h21, 8'h11, 8'h01, 8'h02, 8'h02};
            nReset = 1'b0;
            clearProgram();
            progMem[8'h00] = mk(5'b01101, 8'h10);
            progMem[8'h10] = mk(5'b01101, 8'h20);
            progMem[8'h20] = mk(5'b01101, 8'h30);
            progMem[8'h30] = mk(5'b01101, 8'h38);
            progMem[8'h38] = mk(5'b01101, 8'h3C);
            progMem[8'h3C] = mk(5'b01110, 8'h00);
            progMem[8'h31] = mk(5'b01110, 8'h00);
            progMem[8'h21] = mk(5'b01110, 8'h00);
            progMem[8'h11] = mk(5'b01110, 8'h00);
            progMem[8'h01] = mk(5'b01110, 8'h00);
            progMem[8'h02] = mk(5'b01111, 8'h00);
            applyStimulus(2);
            nReset = 1'b1;
            for (int i = 0; i < 11; i++) begin
                applyStimulus(1);
                checkOutput("call_ret_pc", 32'(pm_addr), 32'(expPc[i]));
            end
        end
`endif

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accu_core.md
# accu_core

Parametrised accumulator processor core, the next generation of the 8-bit single-cycle core. It fetches one instruction per cycle from an external asynchronous program memory and executes it against an internal accumulator, flags and register file. Compared with the previous generation it adds configurable data/PC width and register count, conditional and unconditional jumps, a zero flag, HALT, and a req/ack handshake to a data memory that may stall. It sits at the top of the processor and owns the program counter, decode, ALU, accumulator, flags and register file.

## Interface
- DATA_W, 8: accumulator, register, operand and data-memory word width; instruction width INS_W = DATA_W+5.
- PC_W, 6: program counter width; must satisfy PC_W <= DATA_W.
- REG_N, 16: register file depth (power of 2, >= 2); register index = operand[$clog2(REG_N)-1:0].
- STACK_D, 4: return-stack depth; used only with ACCU_CORE_CALL_EN.
- clk  in  1  clock, all state updates on rising edge.
- nReset  in  1  synchronous, active-low reset.
- pm_addr  out  PC_W  program memory address (= PC register).
- pm_ins  in  INS_W  instruction at pm_addr, valid in the same cycle; opcode = [INS_W-1:DATA_W], operand k = [DATA_W-1:0].
- dm_req  out  1  data-memory request, registered.
- dm_we  out  1  1 = write, 0 = read; valid while dm_req=1.
- dm_addr  out  DATA_W  data-memory address; valid while dm_req=1.
- dm_wdata  out  DATA_W  write data (accumulator snapshot); valid while dm_req=1.
- dm_rdata  in  DATA_W  read data, sampled in the cycle dm_ack=1.
- dm_ack  in  1  transfer complete.
- accu  out  DATA_W  accumulator register.
- carry  out  1  carry flag register.
- zero  out  1  zero flag register.
- halted  out  1  high in HALT state.

## Operation
- States: RUN, WAIT, HALT. Reset → RUN.
- Opcode[4]=1: ALU op. Source B = k if opcode[3]=0, else R[k]. func = opcode[2:0]: 0 ADD A+B; 1 ADC A+B+C; 2 SUB A+~B+1 (C=1 means no borrow); 3 AND; 4 OR; 5 XOR; 6 SHL (C←A[MSB], A←A<<1); 7 SHR (C←A[0], A←A>>1). Result truncated to DATA_W; C = bit DATA_W of the extended sum for 0–2; AND/OR/XOR leave C unchanged. Z←(result==0) for all ALU ops.
- Opcode[4]=0: 00000 NOP; 00001 LDI A←k; 00010 LDR A←R[k]; 00011 STR R[k]←A; 00100 LDM A←DM[k]; 00101 STM DM[k]←A; 01000 JMP; 01001 JZ; 01010 JNZ; 01011 JC; 01100 JNC; 01111 HALT; all other codes execute as NOP. LDI/LDR/LDM update Z; C is unaffected.
- Jumps: target = k[PC_W-1:0]. Taken → PC←target; not taken → PC←PC+1.
- Non-memory, non-HALT instructions: executed in one RUN cycle, PC←PC+1 (mod 2^PC_W, wraps to 0).
- LDM/STM in RUN: dm_req←1, dm_we, dm_addr←k, dm_wdata←A registered; state→WAIT; PC holds. In WAIT, all outputs are held stable until dm_ack=1. Then dm_req←0, LDM loads A←dm_rdata and updates Z, PC←PC+1, state→RUN.
- dm_ack outside WAIT is ignored.
- HALT: state→HALT, halted=1, PC holds, no further updates; only reset exits.
- Reset (any state, including mid-WAIT): PC=0, A=0, C=0, Z=0, all R[i]=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, halted=0, stack empty. An abandoned transfer is not completed, and a later ack is ignored.

## Timing
- Fetch/decode combinational from pm_ins; all results visible on outputs one edge later, available to the next instruction without hazard.
- Throughput: 1 instruction/cycle; LDM/STM take 1 + N cycles, where N >= 1 is the number of WAIT cycles up to and including the ack cycle.
- dm_req rises the edge after LDM/STM is decoded and falls the edge after dm_ack is sampled high.

## Configuration
- ACCU_CORE_CALL_EN defined: 01101 CALL pushes PC+1 to a STACK_D-entry return stack, then PC←target. 01110 RET pops to PC. CALL when full: jump taken, push dropped. RET when empty: acts as NOP.
- Not defined: 01101/01110 execute as NOP and no stack is built.

## Test plan
- Reset held 2 cycles with pm_ins=LDI 0x55 → accu=0, pm_addr=0, dm_req=0; first edge after release gives accu=0x55, pm_addr=1.
- Program LDI 0xF0; ADDI 0x20; ADCI 0x00 → accu 0xF0, then 0x10 with carry=1, then 0x11 with carry=0, zero=0.
- LDI 0x03; STM 0x40 with dm_ack delayed 3 cycles → dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0x03 held stable 3 cycles; PC advances only after ack. LDM 0x40 with dm_rdata=0xA5 → accu=0xA5.
- LDI 0; JZ 0x3F; at 0x3F NOP → pm_addr goes 1→0x3F→0x00 (wrap); JNZ under the same condition is not taken.
- HALT → halted=1, pm_addr frozen for 10 cycles; nReset low asserted while in WAIT → dm_req=0 next edge, and a late dm_ack does not change accu.
- With ACCU_CORE_CALL_EN and STACK_D=4: 5 nested CALLs then 5 RETs → the first 4 RETs return correctly, the 5th acts as NOP.
